acumulador_suma: RTL and testbench
==================================

// Module: acumulador_suma
// PURPOSE
//   Consumer stage placed directly downstream of the 2-bit adder (sumador2bits).
//   Each accepted sample is the adder result {Cout,S} (value 0..6).
//   The block accumulates N_SAMPLES samples into an ACC_W-bit register.
//   It then presents the total on a valid/ready output port and restarts.
// PARAMETERS
//   ACC_W      8   accumulator width in bits; the sum wraps modulo 2**ACC_W
//   N_SAMPLES  64  samples per accumulation frame; legal range >= 1
// PORTS
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   clr        in   1       synchronous frame abort/clear
//   in_valid   in   1       {Cout,S} sample valid this cycle
//   in_ready   out  1       block can accept a sample
//   Cout       in   1       adder carry-out (sample bit 2)
//   S          in   2       adder sum (sample bits 1:0)
//   acc        out  ACC_W   running / final accumulated value
//   ovf        out  1       sticky: the accumulator wrapped at least once this frame
//   count      out  CNT_W   samples accepted this frame; CNT_W = $clog2(N_SAMPLES+1)
//   out_valid  out  1       frame result valid on acc/ovf
//   out_ready  in   1       downstream takes the result
// BEHAVIOUR
//   Reset (rst_n=0, any time, async): state=ACCUM, acc=0, ovf=0, count=0,
//     out_valid=0, in_ready=1. An in-progress frame is discarded.
//   State ACCUM: in_ready=1, out_valid=0.
//     Accept = in_valid & in_ready.
//     On accept, next edge: acc <= acc + {Cout,S} (zero-extended); count <= count+1.
//     Set ovf if the (ACC_W+1)-bit sum has its MSB set. ovf stays set until the frame ends.
//   ACCUM->HOLD: on the edge that accepts sample number N_SAMPLES.
//     out_valid=1 from the next cycle (1-cycle latency). count==N_SAMPLES in HOLD.
//   State HOLD: in_ready=0; acc, ovf and count are frozen. in_valid is ignored (no accept).
//   HOLD->ACCUM: on an edge with out_ready=1. Same edge clears acc, ovf and count.
//     in_ready=1 from the next cycle; no sample is accepted on the handoff edge.
//   clr=1 (sync): top priority over accept and handoff.
//     Next edge: state=ACCUM, acc=0, ovf=0, count=0, out_valid=0.
//     A sample presented with clr=1 is dropped.
//   out_valid must not deassert without a handoff, clr or reset.
//   acc/ovf must be stable while out_valid=1 & out_ready=0.
//   in_valid=0 in ACCUM: acc and count hold.
//   N_SAMPLES=1: every accepted sample goes straight to HOLD.
//   No combinational path from any input to any output except through state.
//     in_ready and out_valid are decoded from the state register only.
// STRUCTURE
//   Shared package acumulador_pkg:
//     - state encoding ST_ACCUM=1'b0, ST_HOLD=1'b1
//     - SAMPLE_W=3 (width of {Cout,S})
//   One natural sub-module: contador_muestras.
//     Frame counter with inc, clr and terminal-count output (count==N_SAMPLES-1 & inc).
//   Datapath: one ACC_W+1 adder, acc register, ovf flop.
//   FSM: 2 states.
//   Bench instantiates sumador2bits upstream, driving Cout/S.
// TESTING
//   1. 64 samples A=3,B=3 (sample 6), out_ready=1
//      -> out_valid 1 cycle after the 64th accept; acc=0x80 (384 mod 256); ovf=1.
//   2. 64 samples A=1,B=0 (sample 1), in_valid toggling every other cycle
//      -> acc=64, ovf=0, count=64; idle cycles do not change acc.
//   3. Backpressure: finish a frame, hold out_ready=0 for 5 cycles while driving in_valid=1
//      -> in_ready=0; acc/ovf/out_valid stable.
//      Then out_ready=1 -> next cycle acc=0, count=0, in_ready=1.
//   4. clr mid-frame: 10 samples of 3 (acc=30), then clr=1 with in_valid=1
//      -> next cycle acc=0, count=0, ovf=0; that sample is not added.
//   5. rst_n low asynchronously mid-frame (count=20) and mid-HOLD
//      -> all outputs reach their reset values without a clock edge.
//      After release, a full frame of sample 2 -> acc=128, ovf=0.
//   6. Exhaustive upstream sweep: all 16 A/B combinations, 4 frames of 16 samples each
//      -> each frame's result equals the scoreboard sum mod 256.

Source files
------------

// File: rtl/acumulador_pkg.sv
// Shared definitions for the accumulator stage that sits downstream of sumador2bits.
package acumulador_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Width of one adder result {Cout,S}
    localparam int SAMPLE_W = 3;

endpackage

// File: rtl/acumulador_suma_contador_muestras.sv
// Frame sample counter; tc flags the increment that completes the frame.
module contador_muestras #(
    parameter int N_SAMPLES = 64,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    // clr wins over inc so a frame abort never leaves a stray count of 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = inc && (count == LAST);

endmodule

// File: rtl/sumador2bits.sv
// Upstream 2-bit adder: {Cout,S} = A + B, producing a 0..6 sample.
module sumador2bits (
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic [1:0] S,
    output logic       Cout
);

    assign {Cout, S} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/acumulador_suma.sv
// Accumulates N_SAMPLES adder results and hands the frame total off over valid/ready.
module acumulador_suma
    import acumulador_pkg::*;
#(
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 64,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             Cout,
    input  logic [1:0]       S,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SUM_W = ACC_W + 1;

    state_t             state;
    logic               accept;
    logic               handoff;
    logic               frame_clr;
    logic               tc;
    logic [SAMPLE_W-1:0] sample;
    logic [SUM_W-1:0]   sum;

    assign sample    = {Cout, S};
    assign accept    = in_valid && (state == ST_ACCUM) && !clr;
    assign handoff   = out_ready && (state == ST_HOLD) && !clr;
    assign frame_clr = clr || handoff;

    // Extra MSB of the adder is the wrap indicator for the sticky ovf flag
    assign sum = {1'b0, acc} + SUM_W'(sample);

    // Handshake flags come straight from the state register, never from inputs
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);

    contador_muestras #(
        .N_SAMPLES (N_SAMPLES),
        .CNT_W     (CNT_W)
    ) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .clr   (frame_clr),
        .count (count),
        .tc    (tc)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            state <= ST_ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        acc <= sum[ACC_W-1:0];
                        ovf <= ovf | sum[ACC_W];
                        if (tc) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (handoff) begin
                        state <= ST_ACCUM;
                        acc   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_suma.sv
// Drives two accumulators (64- and 16-sample frames) from one sumador2bits and
// compares every cycle against a running-total model of each frame.
module tb_acumulador_suma;

    localparam int ACC_W = 8;
    localparam int N0    = 64;
    localparam int N1    = 16;
    localparam int W0    = $clog2(N0 + 1);
    localparam int W1    = $clog2(N1 + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [1:0]       a = 2'd0;
    logic [1:0]       b = 2'd0;
    logic [1:0]       s;
    logic             cout;

    logic             in_ready0, ovf0, out_valid0;
    logic [ACC_W-1:0] acc0;
    logic [W0-1:0]    count0;
    logic             in_ready1, ovf1, out_valid1;
    logic [ACC_W-1:0] acc1;
    logic [W1-1:0]    count1;

    int n_cmp = 0;
    int n_err = 0;

    // Model: running total and accepted-sample count per DUT; HOLD is count == frame length
    int tot [2];
    int cnt [2];
    int nsm [2];

    always #5 clk = ~clk;

    sumador2bits u_sum (.A(a), .B(b), .S(s), .Cout(cout));

    acumulador_suma #(.ACC_W(ACC_W), .N_SAMPLES(N0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .Cout(cout), .S(s), .acc(acc0), .ovf(ovf0), .count(count0),
        .out_valid(out_valid0), .out_ready(out_ready)
    );

    acumulador_suma #(.ACC_W(ACC_W), .N_SAMPLES(N1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .Cout(cout), .S(s), .acc(acc1), .ovf(ovf1), .count(count1),
        .out_valid(out_valid1), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("acc0",       32'(acc0),       32'(tot[0] % 256));
        check("ovf0",       32'(ovf0),       32'(tot[0] >= 256));
        check("count0",     32'(count0),     32'(cnt[0]));
        check("out_valid0", 32'(out_valid0), 32'(cnt[0] == nsm[0]));
        check("in_ready0",  32'(in_ready0),  32'(cnt[0] != nsm[0]));
        check("acc1",       32'(acc1),       32'(tot[1] % 256));
        check("ovf1",       32'(ovf1),       32'(tot[1] >= 256));
        check("count1",     32'(count1),     32'(cnt[1]));
        check("out_valid1", 32'(out_valid1), 32'(cnt[1] == nsm[1]));
        check("in_ready1",  32'(in_ready1),  32'(cnt[1] != nsm[1]));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            tot[d] = 0;
            cnt[d] = 0;
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, compare 1 ns later
    task automatic cyc(input logic [1:0] ta, input logic [1:0] tb_v,
                       input logic iv, input logic ordy, input logic cl);
        a = ta; b = tb_v; in_valid = iv; out_ready = ordy; clr = cl;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (cl) begin
                tot[d] = 0;
                cnt[d] = 0;
            end else if (cnt[d] < nsm[d]) begin
                if (iv) begin
                    tot[d] += int'(ta) + int'(tb_v);
                    cnt[d]++;
                end
            end else if (ordy) begin
                tot[d] = 0;
                cnt[d] = 0;
            end
        end
        #1;
        check_all();
    endtask

    task automatic rand_cyc(input logic iv, input logic ordy);
        cyc(2'($urandom_range(3)), 2'($urandom_range(3)), iv, ordy, 1'b0);
    endtask

    // Asserts rst_n between edges, checks reset values before any edge, releases off-edge
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [ACC_W-1:0] snap;
        int               fs;

        nsm[0] = N0;
        nsm[1] = N1;
        model_reset();

        #3;
        check_all();
        #9 rst_n = 1'b1;

        // Sample 6 for a whole frame wraps past 256 and lands on 0x80
        for (int i = 0; i < N0; i++) cyc(2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
        check("t1_acc", 32'(acc0), 32'h80);
        check("t1_ovf", 32'(ovf0), 32'd1);
        cyc(2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

        // Sample 1 on alternate cycles; idle cycles must leave acc unchanged
        for (int i = 0; i < 2 * N0; i++) cyc(2'd1, 2'd0, (i % 2) == 0, 1'b0, 1'b0);
        check("t2_acc",   32'(acc0),   32'd64);
        check("t2_count", 32'(count0), 32'd64);
        cyc(2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

        // Backpressure with in_valid held high while the result waits
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < N0; i++) rand_cyc(1'b1, 1'b0);
        snap = acc0;
        for (int i = 0; i < 5; i++) begin
            rand_cyc(1'b1, 1'b0);
            check("t3_hold_acc", 32'(acc0), 32'(snap));
        end
        rand_cyc(1'b1, 1'b1);
        check("t3_hand_acc",   32'(acc0),     32'd0);
        check("t3_hand_ready", 32'(in_ready0), 32'd1);

        // clr mid-frame drops the sample presented with it
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(2'd1, 2'd2, 1'b1, 1'b1, 1'b0);
        check("t4_acc30", 32'(acc0), 32'd30);
        cyc(2'd3, 2'd3, 1'b1, 1'b0, 1'b1);
        check("t4_clr_acc", 32'(acc0), 32'd0);

        // Async reset mid-frame, then mid-HOLD, then a clean frame of sample 2
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) rand_cyc(1'b1, 1'b0);
        async_reset();
        for (int i = 0; i < N0; i++) rand_cyc(1'b1, 1'b0);
        check("t5_in_hold", 32'(out_valid0), 32'd1);
        async_reset();
        for (int i = 0; i < N0; i++) cyc(2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
        check("t5_acc128", 32'(acc0), 32'd128);
        check("t5_ovf",    32'(ovf0), 32'd0);
        cyc(2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

        // Exhaustive A/B sweep: 16-sample frames on u_dut1, one 64-sample frame on u_dut0
        cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 4; f++) begin
            fs = 0;
            for (int k = 0; k < 16; k++) begin
                cyc(2'(k >> 2), 2'(k & 3), 1'b1, 1'b0, 1'b0);
                fs += (k >> 2) + (k & 3);
            end
            check("t6_frame16", 32'(acc1), 32'(fs % 256));
            if (f == 3) check("t6_frame64", 32'(acc0), 32'd192);
            cyc(2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        end

        // Fully random traffic including occasional clr
        for (int i = 0; i < 400; i++) begin
            rand_cyc(1'($urandom_range(1)), 1'($urandom_range(3) == 0));
            if ($urandom_range(49) == 0) cyc(2'd3, 2'd3, 1'b1, 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
